// File: rtl/bus_wdt_pkg.sv
// bus_wdt_pkg: shared state encoding, parameter limits and width helper for bus_watchdog
package bus_wdt_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, TERM = 2'd2, BERR = 2'd3} state_t;
  localparam int TIMEOUT_MIN = 2;
  localparam int TIMEOUT_MAX = 65535;
  localparam int PRESCALE_MIN = 1;
  localparam int PRESCALE_MAX = 256;
  function automatic int wdt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/bus_wdt_tick.sv
// bus_wdt_tick: clock prescaler, tick when the count reaches PRESCALE-1, held at 0 by restart
module bus_wdt_tick
  import bus_wdt_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  localparam int PW = wdt_width(PRESCALE);
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  logic [PW-1:0] p;
  assign tick = p == PMAX;
  always_ff @(posedge clk or negedge reset)
    if (!reset) p <= '0;
    else p <= (restart || tick) ? '0 : p + 1'b1;
endmodule

// File: rtl/bus_watchdog.sv
// bus_watchdog: 68000 bus-cycle watchdog driving /BERR on timeout; BUS_WDT_ADDR_LATCH_EN adds fault_addr capture
module bus_watchdog
  import bus_wdt_pkg::*;
#(
  parameter int TIMEOUT  = 8,
  parameter int PRESCALE = 1,
  parameter int AW       = 23
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          as,
  input  logic          dtack,
  input  logic          vpa,
  input  logic          dis,
  input  logic          fault_clr,
`ifdef BUS_WDT_ADDR_LATCH_EN
  input  logic [AW-1:0] addr,
  output logic [AW-1:0] fault_addr,
`endif
  output logic          berr,
  output logic          fault
);
  localparam int CW = wdt_width(TIMEOUT);
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);
  if (TIMEOUT < TIMEOUT_MIN || TIMEOUT > TIMEOUT_MAX || PRESCALE < PRESCALE_MIN ||
      PRESCALE > PRESCALE_MAX || AW < 1) begin : g_bad_param
    $fatal(1, "bus_watchdog: illegal parameter value");
  end
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic tick, term, set;
  assign term = !dtack || !vpa;
  assign set = (state == COUNT) && (nxt == BERR);
  bus_wdt_tick #(.PRESCALE(PRESCALE)) u_tick (
    .clk(clk), .reset(reset), .restart(state != COUNT), .tick(tick)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = as ? IDLE : (term || dis) ? TERM : COUNT;
      COUNT:   nxt = as ? IDLE : (term || dis) ? TERM : (tick && cnt == CMAX) ? BERR : COUNT;
      default: nxt = as ? IDLE : state;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      berr  <= 1'b1;
      fault <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= (state != COUNT) ? '0 : (tick && cnt != CMAX) ? cnt + 1'b1 : cnt;
      berr  <= nxt != BERR;
      fault <= set ? 1'b1 : fault_clr ? 1'b0 : fault;
    end
`ifdef BUS_WDT_ADDR_LATCH_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) fault_addr <= '0;
    else if (set) fault_addr <= addr;
`endif
endmodule

// File: tb/tb_bus_watchdog.sv
// tb_bus_watchdog: directed self-checking bench for bus_watchdog (8/1 and 4/3 configurations)
module tb_bus_watchdog;
  logic clk = 0, reset = 0, as = 1, dtack = 1, vpa = 1, dis = 0, fault_clr = 0;
  logic berr, fault, berr2, fault2;
  int total = 0, bad = 0;
`ifdef BUS_WDT_ADDR_LATCH_EN
  logic [22:0] addr = '0, fault_addr, fault_addr2;
`endif
  always #5 clk = ~clk;
  bus_watchdog #(.TIMEOUT(8), .PRESCALE(1), .AW(23)) dut (
    .clk(clk), .reset(reset), .as(as), .dtack(dtack), .vpa(vpa), .dis(dis),
    .fault_clr(fault_clr),
`ifdef BUS_WDT_ADDR_LATCH_EN
    .addr(addr), .fault_addr(fault_addr),
`endif
    .berr(berr), .fault(fault)
  );
  bus_watchdog #(.TIMEOUT(4), .PRESCALE(3), .AW(23)) dut2 (
    .clk(clk), .reset(reset), .as(as), .dtack(dtack), .vpa(vpa), .dis(dis),
    .fault_clr(fault_clr),
`ifdef BUS_WDT_ADDR_LATCH_EN
    .addr(addr), .fault_addr(fault_addr2),
`endif
    .berr(berr2), .fault(fault2)
  );
  task automatic edge_();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_fault();
    fault_clr = 1;
    edge_();
    fault_clr = 0;
  endtask
  task automatic test_reset();
    reset = 0;
    edge_();
    total++; if (berr !== 1'b1) begin bad++; $display("FAIL reset_berr got=%b want=1", berr); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b want=0", fault); end
    total++; if (berr2 !== 1'b1) begin bad++; $display("FAIL reset_berr2 got=%b want=1", berr2); end
`ifdef BUS_WDT_ADDR_LATCH_EN
    total++; if (fault_addr !== 23'h0) begin bad++; $display("FAIL reset_faddr got=%h want=0", fault_addr); end
`endif
    edge_();
    reset = 1;
    edge_();
  endtask
  task automatic test_timeout();
    as = 0;
    edge_();
    for (int i = 1; i <= 7; i++) begin
      edge_();
      total++; if (berr !== 1'b1) begin bad++; $display("FAIL to_early edge=%0d got=%b want=1", i, berr); end
    end
    edge_();
    total++; if (berr !== 1'b0) begin bad++; $display("FAIL to_berr got=%b want=0", berr); end
    total++; if (fault !== 1'b1) begin bad++; $display("FAIL to_fault got=%b want=1", fault); end
    as = 1;
    edge_();
    total++; if (berr !== 1'b1) begin bad++; $display("FAIL to_release got=%b want=1", berr); end
    total++; if (fault !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b want=1", fault); end
  endtask
  task automatic test_prescale();
    clear_fault();
    total++; if (fault2 !== 1'b0) begin bad++; $display("FAIL ps_clr got=%b want=0", fault2); end
    as = 0;
    edge_();
    for (int i = 1; i <= 11; i++) begin
      edge_();
      total++; if (berr2 !== 1'b1) begin bad++; $display("FAIL ps_early edge=%0d got=%b want=1", i, berr2); end
    end
    edge_();
    total++; if (berr2 !== 1'b0) begin bad++; $display("FAIL ps_berr got=%b want=0", berr2); end
    total++; if (fault2 !== 1'b1) begin bad++; $display("FAIL ps_fault got=%b want=1", fault2); end
    as = 1;
    edge_();
    total++; if (berr2 !== 1'b1) begin bad++; $display("FAIL ps_release got=%b want=1", berr2); end
  endtask
  task automatic test_dtack();
    clear_fault();
    as = 0;
    edge_();
    for (int i = 1; i <= 4; i++) edge_();
    dtack = 0;
    for (int i = 5; i <= 12; i++) edge_();
    total++; if (berr !== 1'b1) begin bad++; $display("FAIL dt_early got=%b want=1", berr); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL dt_fault got=%b want=0", fault); end
    as = 1;
    dtack = 1;
    edge_();
    as = 0;
    edge_();
    for (int i = 1; i <= 7; i++) edge_();
    vpa = 0;
    edge_();
    total++; if (berr !== 1'b1) begin bad++; $display("FAIL dt_coinc got=%b want=1", berr); end
    vpa = 1;
    for (int i = 0; i < 4; i++) edge_();
    total++; if (berr !== 1'b1) begin bad++; $display("FAIL dt_term got=%b want=1", berr); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL dt_coinc_fault got=%b want=0", fault); end
    as = 1;
    edge_();
  endtask
  task automatic test_dis();
    int lows = 0;
    dis = 1;
    as = 0;
    edge_();
    for (int i = 1; i <= 50; i++) begin
      edge_();
      if (berr !== 1'b1) lows++;
    end
    total++; if (lows !== 0) begin bad++; $display("FAIL dis_start low_edges=%0d want=0", lows); end
    as = 1;
    dis = 0;
    edge_();
    as = 0;
    edge_();
    for (int i = 1; i <= 8; i++) edge_();
    total++; if (berr !== 1'b0) begin bad++; $display("FAIL dis_pre got=%b want=0", berr); end
    dis = 1;
    dtack = 0;
    for (int i = 0; i < 5; i++) edge_();
    total++; if (berr !== 1'b0) begin bad++; $display("FAIL dis_hold got=%b want=0", berr); end
    as = 1;
    edge_();
    total++; if (berr !== 1'b1) begin bad++; $display("FAIL dis_release got=%b want=1", berr); end
    dis = 0;
    dtack = 1;
  endtask
  task automatic test_fault_clr();
    clear_fault();
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL fc_alone got=%b want=0", fault); end
`ifdef BUS_WDT_ADDR_LATCH_EN
    addr = 23'h7FFFFF;
`endif
    as = 0;
    edge_();
    for (int i = 1; i <= 7; i++) edge_();
    fault_clr = 1;
    edge_();
    fault_clr = 0;
    total++; if (fault !== 1'b1) begin bad++; $display("FAIL fc_set_wins got=%b want=1", fault); end
`ifdef BUS_WDT_ADDR_LATCH_EN
    total++; if (fault_addr !== 23'h7FFFFF) begin bad++; $display("FAIL fc_faddr got=%h want=7fffff", fault_addr); end
    addr = 23'h012345;
`endif
    clear_fault();
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL fc_clear got=%b want=0", fault); end
    total++; if (berr !== 1'b0) begin bad++; $display("FAIL fc_berr got=%b want=0", berr); end
`ifdef BUS_WDT_ADDR_LATCH_EN
    total++; if (fault_addr !== 23'h7FFFFF) begin bad++; $display("FAIL fc_faddr_hold got=%h want=7fffff", fault_addr); end
`endif
    as = 1;
    edge_();
  endtask
  task automatic test_reset_mid();
    as = 0;
    edge_();
    for (int i = 1; i <= 5; i++) edge_();
    #2 reset = 0;
    #1;
    total++; if (berr !== 1'b1) begin bad++; $display("FAIL rm_count_berr got=%b want=1", berr); end
    reset = 1;
    edge_();
    for (int i = 1; i <= 8; i++) edge_();
    total++; if (berr !== 1'b0) begin bad++; $display("FAIL rm_pre got=%b want=0", berr); end
    total++; if (fault !== 1'b1) begin bad++; $display("FAIL rm_pre_fault got=%b want=1", fault); end
    #2 reset = 0;
    #1;
    total++; if (berr !== 1'b1) begin bad++; $display("FAIL rm_berr got=%b want=1", berr); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL rm_fault got=%b want=0", fault); end
    edge_();
    reset = 1;
    edge_();
    for (int i = 1; i <= 7; i++) begin
      edge_();
      total++; if (berr !== 1'b1) begin bad++; $display("FAIL rm_retime edge=%0d got=%b want=1", i, berr); end
    end
    edge_();
    total++; if (berr !== 1'b0) begin bad++; $display("FAIL rm_retime_berr got=%b want=0", berr); end
    as = 1;
    edge_();
    total++; if (berr !== 1'b1) begin bad++; $display("FAIL rm_end got=%b want=1", berr); end
  endtask
  task automatic test_back_to_back();
    clear_fault();
    as = 0;
    edge_();
    for (int i = 1; i <= 5; i++) edge_();
    as = 1;
    edge_();
    as = 0;
    edge_();
    for (int i = 1; i <= 7; i++) edge_();
    total++; if (berr !== 1'b1) begin bad++; $display("FAIL b2b_carry got=%b want=1", berr); end
    edge_();
    total++; if (berr !== 1'b0) begin bad++; $display("FAIL b2b_berr got=%b want=0", berr); end
    as = 1;
    edge_();
  endtask
  initial begin
    test_reset();
    test_timeout();
    test_prescale();
    test_dtack();
    test_dis();
    test_fault_clr();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
